// File: rtl/fifo_wr_pack.sv
// Packs an 8-bit pixel stream into little-endian 32-bit FIFO words, framed by i_fval.
// A guard window after each front-FIFO reset holds off writes; lost data sets a sticky flag.
module fifo_wr_pack #(
    parameter int unsigned RST_GUARD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_fval,
    input  logic        i_dval,
    input  logic [7:0]  iv_pix_data,
    input  logic        i_rst_buf,
    input  logic        i_fifo_full,
    output logic        o_fifo_wr_en,
    output logic [31:0] ov_fifo_din,
    output logic        o_frame_done,
    output logic        o_overflow,
    output logic [15:0] ov_word_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StGuard,
        StActive
    } state_t;

    localparam logic [3:0] GuardLast = 4'(RST_GUARD - 1);

    state_t      state;
    logic [3:0]  guard_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] pack_buf;
    logic [31:0] full_word;
    logic [31:0] flush_word;
    logic [15:0] word_cnt_inc;

    // pack_buf may hold stale upper bytes, so a flush masks by byte_cnt.
    always_comb begin
        full_word = {iv_pix_data, pack_buf};
        unique case (byte_cnt)
            2'd1:    flush_word = {24'h0, pack_buf[7:0]};
            2'd2:    flush_word = {16'h0, pack_buf[15:0]};
            default: flush_word = {8'h0, pack_buf};
        endcase
        word_cnt_inc = (ov_word_cnt == 16'hFFFF) ? ov_word_cnt : ov_word_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            guard_cnt    <= '0;
            byte_cnt     <= '0;
            pack_buf     <= '0;
            o_fifo_wr_en <= 1'b0;
            ov_fifo_din  <= '0;
            o_frame_done <= 1'b0;
            o_overflow   <= 1'b0;
            ov_word_cnt  <= '0;
        end else begin
            o_fifo_wr_en <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_rst_buf) begin
                state       <= StGuard;
                guard_cnt   <= '0;
                byte_cnt    <= '0;
                o_overflow  <= 1'b0;
                ov_word_cnt <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        state <= StIdle;
                    end
                    StGuard: begin
                        if (!i_fval) begin
                            state        <= StIdle;
                            o_frame_done <= 1'b1;
                        end else begin
                            if (i_dval) begin
                                o_overflow <= 1'b1;
                            end
                            if (guard_cnt == GuardLast) begin
                                state <= StActive;
                            end else begin
                                guard_cnt <= guard_cnt + 4'd1;
                            end
                        end
                    end
                    StActive: begin
                        if (!i_fval) begin
                            state        <= StIdle;
                            o_frame_done <= 1'b1;
                            byte_cnt     <= '0;
                            if (byte_cnt != 2'd0) begin
                                if (i_fifo_full) begin
                                    o_overflow <= 1'b1;
                                end else begin
                                    o_fifo_wr_en <= 1'b1;
                                    ov_fifo_din  <= flush_word;
                                    ov_word_cnt  <= word_cnt_inc;
                                end
                            end
                        end else if (i_dval) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                if (i_fifo_full) begin
                                    o_overflow <= 1'b1;
                                end else begin
                                    o_fifo_wr_en <= 1'b1;
                                    ov_fifo_din  <= full_word;
                                    ov_word_cnt  <= word_cnt_inc;
                                end
                            end else begin
                                pack_buf[byte_cnt*8 +: 8] <= iv_pix_data;
                            end
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_pack.sv
// Directed and randomized frames for fifo_wr_pack, checked against a byte-list model.
module tb_fifo_wr_pack;

    localparam int unsigned GUARD = 4;

    logic        clk;
    logic        reset;
    logic        i_fval;
    logic        i_dval;
    logic [7:0]  iv_pix_data;
    logic        i_rst_buf;
    logic        i_fifo_full;
    logic        o_fifo_wr_en;
    logic [31:0] ov_fifo_din;
    logic        o_frame_done;
    logic        o_overflow;
    logic [15:0] ov_word_cnt;

    fifo_wr_pack #(.RST_GUARD(GUARD)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_fval       (i_fval),
        .i_dval       (i_dval),
        .iv_pix_data  (iv_pix_data),
        .i_rst_buf    (i_rst_buf),
        .i_fifo_full  (i_fifo_full),
        .o_fifo_wr_en (o_fifo_wr_en),
        .ov_fifo_din  (ov_fifo_din),
        .o_frame_done (o_frame_done),
        .o_overflow   (o_overflow),
        .ov_word_cnt  (ov_word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;

    // Model: expected sticky flag, word count, last written word, and the word being assembled.
    logic        exp_ovf;
    int          exp_cnt;
    logic [31:0] last_din;
    logic [31:0] cur_word;
    int          nb;
    int          widx;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input logic exp_wr, input logic exp_done);
        check("wr_en", 32'(o_fifo_wr_en), 32'(exp_wr));
        check("frame_done", 32'(o_frame_done), 32'(exp_done));
        check("din", ov_fifo_din, last_din);
        check("overflow", 32'(o_overflow), 32'(exp_ovf));
        check("word_cnt", 32'(ov_word_cnt), exp_cnt);
    endtask

    task automatic start_frame(input bit guard_drop, input int guard_steps);
        i_fval    = 1'b1;
        i_dval    = 1'b0;
        i_rst_buf = 1'b1;
        step();
        i_rst_buf = 1'b0;
        exp_ovf   = 1'b0;
        exp_cnt   = 0;
        cur_word  = '0;
        nb        = 0;
        widx      = 0;
        check_cycle(1'b0, 1'b0);
        for (int g = 0; g < guard_steps; g++) begin
            i_dval      = guard_drop && (g == 1);
            iv_pix_data = 8'($urandom);
            i_fifo_full = 1'($urandom_range(1));
            if (i_dval) exp_ovf = 1'b1;
            step();
            check_cycle(1'b0, 1'b0);
        end
        i_dval = 1'b0;
    endtask

    task automatic send_bytes(input int nbytes, input logic [7:0] base, input bit rnd,
                              input int full_mask, input int full_pct, input int gap_pct);
        int   k;
        logic exp_wr;
        logic fullb;
        logic [7:0] b;
        k = 0;
        while (k < nbytes) begin
            exp_wr = 1'b0;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                i_dval      = 1'b0;
                iv_pix_data = 8'($urandom);
                i_fifo_full = 1'($urandom_range(1));
            end else begin
                b     = rnd ? 8'($urandom) : base + 8'(k);
                fullb = ((nb == 3) && full_mask[widx]) || ($urandom_range(99) < full_pct);
                i_dval      = 1'b1;
                iv_pix_data = b;
                i_fifo_full = fullb;
                cur_word[nb*8 +: 8] = b;
                nb++;
                k++;
                if (nb == 4) begin
                    if (fullb) begin
                        exp_ovf = 1'b1;
                    end else begin
                        exp_wr   = 1'b1;
                        last_din = cur_word;
                        exp_cnt++;
                    end
                    nb       = 0;
                    cur_word = '0;
                    widx++;
                end
            end
            step();
            check_cycle(exp_wr, 1'b0);
        end
        i_dval      = 1'b0;
        i_fifo_full = 1'b0;
    endtask

    task automatic end_frame(input int full_pct);
        logic exp_wr;
        i_fval      = 1'b0;
        i_dval      = 1'($urandom_range(1));
        i_fifo_full = ($urandom_range(99) < full_pct);
        exp_wr      = (nb != 0) && !i_fifo_full;
        if (nb != 0 && i_fifo_full) exp_ovf = 1'b1;
        if (exp_wr) begin
            last_din = cur_word;
            exp_cnt++;
        end
        nb       = 0;
        cur_word = '0;
        step();
        check_cycle(exp_wr, 1'b1);
        // Idle data after the frame must be ignored and flags must hold.
        i_dval      = 1'b1;
        i_fifo_full = 1'b0;
        step();
        check_cycle(1'b0, 1'b0);
        i_dval = 1'b0;
        step();
        check_cycle(1'b0, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        i_fval      = 1'b1;
        i_dval      = 1'b1;
        iv_pix_data = 8'hA5;
        i_rst_buf   = 1'b1;
        i_fifo_full = 1'b0;
        exp_ovf     = 1'b0;
        exp_cnt     = 0;
        last_din    = '0;
        cur_word    = '0;
        nb          = 0;
        widx        = 0;
        repeat (3) step();
        check_cycle(1'b0, 1'b0);

        reset     = 1'b0;
        i_rst_buf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_dval = 1'b1;
            step();
            check_cycle(1'b0, 1'b0);
        end
        i_fval = 1'b0;
        i_dval = 1'b0;
        step();

        // Full-word frame.
        start_frame(1'b0, GUARD);
        send_bytes(8, 8'h01, 1'b0, 0, 0, 0);
        end_frame(0);
        check("frame1_last", last_din, 32'h08070605);

        // Partial flush.
        start_frame(1'b0, GUARD);
        send_bytes(6, 8'h11, 1'b0, 0, 0, 0);
        end_frame(0);
        check("flush_word", last_din, 32'h00001615);

        // Full drop on the first word.
        start_frame(1'b0, GUARD);
        send_bytes(8, 8'h41, 1'b0, 1, 0, 0);
        end_frame(0);

        // Guard drop.
        start_frame(1'b1, GUARD);
        send_bytes(4, 8'h31, 1'b0, 0, 0, 0);
        end_frame(0);
        check("guard_word", last_din, 32'h34333231);

        // Frame ends inside the guard window.
        start_frame(1'b0, 2);
        i_fval = 1'b0;
        step();
        check_cycle(1'b0, 1'b1);
        step();
        check_cycle(1'b0, 1'b0);

        // Reset mid-frame discards the partial word.
        start_frame(1'b0, GUARD);
        send_bytes(2, 8'h51, 1'b0, 0, 0, 0);
        i_dval = 1'b1;
        reset  = 1'b1;
        step();
        exp_ovf  = 1'b0;
        exp_cnt  = 0;
        last_din = '0;
        check_cycle(1'b0, 1'b0);
        reset  = 1'b0;
        i_dval = 1'b0;
        i_fval = 1'b0;
        step();
        check_cycle(1'b0, 1'b0);
        step();
        check_cycle(1'b0, 1'b0);
        start_frame(1'b0, GUARD);
        send_bytes(4, 8'h21, 1'b0, 0, 0, 0);
        end_frame(0);
        check("after_reset", last_din, 32'h24232221);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            start_frame(1'($urandom_range(1)), GUARD);
            send_bytes(int'($urandom_range(13)), 8'h00, 1'b1, 0, 20, 25);
            end_frame(30);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_pack.md
FIFO_WR_PACK -- requirements
Module: fifo_wr_pack

Interface
REQ-001 Parameter RST_GUARD, default 4, meaning the number of cycles to hold off writes after a front-FIFO reset pulse (legal range 1..15).
REQ-002 Port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port i_fval, input, 1 bit: frame valid.
REQ-005 Port i_dval, input, 1 bit: pixel valid; qualified by i_fval.
REQ-006 Port iv_pix_data, input, 8 bits: pixel byte.
REQ-007 Port i_rst_buf, input, 1 bit: one-cycle front-FIFO reset pulse, registered from the i_fval rising edge.
REQ-008 Port i_fifo_full, input, 1 bit: front-FIFO full flag.
REQ-009 Port o_fifo_wr_en, output, 1 bit: FIFO write strobe.
REQ-010 Port ov_fifo_din, output, 32 bits: packed FIFO write word.
REQ-011 Port o_frame_done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-012 Port o_overflow, output, 1 bit: sticky per-frame data-loss flag.
REQ-013 Port ov_word_cnt, output, 16 bits: number of words accepted in the current frame.

Function
REQ-014 The block SHALL implement states IDLE, GUARD and ACTIVE, and all outputs SHALL be registered.
REQ-015 i_rst_buf=1 in any state SHALL cause the following on the next edge:
  - state <= GUARD;
  - guard counter <= 0, byte count <= 0;
  - o_overflow <= 0, ov_word_cnt <= 0.
REQ-016 GUARD SHALL last exactly RST_GUARD cycles, then the block SHALL enter ACTIVE.
REQ-017 If i_dval=1 and i_fval=1 are sampled while in GUARD, the byte SHALL be discarded and o_overflow set.
REQ-018 If i_fval=0 is sampled in GUARD, the block SHALL return to IDLE and pulse o_frame_done with no write.
REQ-019 In ACTIVE, each byte with i_dval=1 and i_fval=1 SHALL be packed little-endian: byte 0 to bits [7:0] through byte 3 to bits [31:24].
REQ-020 When the 4th byte is sampled at edge E, the following SHALL hold in the cycle after E (1-cycle latency):
  - ov_fifo_din SHALL hold the packed word;
  - o_fifo_wr_en SHALL be 1 if i_fifo_full=0 at edge E;
  - the byte count SHALL wrap to 0.
REQ-021 If i_fifo_full=1 at that edge, the word SHALL be dropped (o_fifo_wr_en=0) and o_overflow set; packing SHALL continue from byte 0.
REQ-022 i_fval=0 sampled in ACTIVE at edge E SHALL end the frame, with the following visible in the cycle after E:
  - o_frame_done=1 for one cycle;
  - state = IDLE;
  - byte count = 0.
REQ-023 At end of frame, a partial word (byte count 1..3) SHALL be flushed in the same cycle as o_frame_done:
  - unfilled bytes zero-padded;
  - write subject to REQ-021.
  With byte count 0, no write SHALL occur.
REQ-024 Bytes with i_fval=0, or any i_dval in IDLE, SHALL be ignored and SHALL NOT set o_overflow.
REQ-025 ov_word_cnt SHALL increment on every accepted write (including a flush) and SHALL saturate at 0xFFFF.
REQ-026 o_fifo_wr_en and o_frame_done SHALL be single-cycle pulses, 0 in every other cycle.
REQ-027 ov_fifo_din SHALL hold its last value when o_fifo_wr_en=0.
REQ-028 o_overflow and ov_word_cnt SHALL hold after end of frame until the next i_rst_buf.

Reset
REQ-029 reset=1 SHALL take priority over i_rst_buf and all other inputs.
REQ-030 While reset=1 the block SHALL set:
  - state = IDLE;
  - byte count and guard counter = 0;
  - o_fifo_wr_en, o_frame_done, o_overflow = 0;
  - ov_fifo_din, ov_word_cnt = 0.
REQ-031 A reset mid-ACTIVE SHALL discard any partial word without a flush write or o_frame_done pulse.

Verification
REQ-032 Reset: assert reset for 3 cycles -> all outputs 0; i_dval pulses in IDLE -> no write, o_overflow=0.
REQ-033 Full-word frame, RST_GUARD=4:
  - stimulus: i_fval rises, i_rst_buf pulses, wait 4 cycles, send bytes 0x01..0x08 back-to-back, drop i_fval;
  - response: writes 0x04030201 then 0x08070605;
  - response: o_frame_done=1 one cycle after the i_fval fall is sampled;
  - response: ov_word_cnt=2, o_overflow=0.
REQ-034 Partial flush: 6 bytes 0x11..0x16 -> writes 0x14131211, then 0x00001615 in the same cycle as o_frame_done; ov_word_cnt=2.
REQ-035 Full drop: i_fifo_full=1 on the edge the 4th byte is sampled -> no write for that word, o_overflow=1, ov_word_cnt unchanged; the next 4 bytes are written normally.
REQ-036 Guard drop: i_dval=1 two cycles into GUARD -> byte lost, o_overflow=1; the first ACTIVE byte lands in bits [7:0].
REQ-037 Reset mid-frame: reset after 2 bytes in ACTIVE -> no write, no o_frame_done; the next frame packs from byte 0 with o_overflow=0.
